// File: rtl/id_stage_if.sv
// ID/EX pipeline bundle between the decode stage (master) and execute (slave).
// ex_valid=1 marks a real instruction; with ex_valid=0 every other field is 0.
interface id_stage_if #(
    parameter int ARQ = 16
);
    logic           ex_valid;
    logic           ex_we;
    logic           ex_mem_rd;
    logic           ex_mem_wr;
    logic [2:0]     ex_alu_op;
    logic [3:0]     ex_rd;
    logic [ARQ-1:0] ex_a;
    logic [ARQ-1:0] ex_b;
    logic [ARQ-1:0] ex_store;

    modport master (
        output ex_valid, ex_we, ex_mem_rd, ex_mem_wr, ex_alu_op, ex_rd, ex_a, ex_b, ex_store
    );
    modport slave (
        input ex_valid, ex_we, ex_mem_rd, ex_mem_wr, ex_alu_op, ex_rd, ex_a, ex_b, ex_store
    );
endinterface

// File: rtl/id_stage.sv
// Decode stage: register file, hazard detection, branch resolution, ID/EX register.
// Optional macro ID_ILLEGAL_TRAP_EN enables the sticky illegal-opcode flag.
module id_stage #(
    parameter int ARQ      = 16,
    parameter int MEM_ADDR = 13
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [ARQ-1:0]      instr,
    input  logic [MEM_ADDR-1:0] pc,
    input  logic                wb_we,
    input  logic [3:0]          wb_rd,
    input  logic [ARQ-1:0]      wb_data,
    input  logic                mem_we,
    input  logic [3:0]          mem_rd,
    output logic                stall,
    output logic                branch_taken,
    output logic [MEM_ADDR-1:0] jump_address,
    id_stage_if.master          ex,
    output logic                illegal_op
);
    logic [3:0] op, f_rd, f_rs1, f_rs2;
    assign op    = instr[15:12];
    assign f_rd  = instr[11:8];
    assign f_rs1 = instr[7:4];
    assign f_rs2 = instr[3:0];

    logic [ARQ-1:0] rf [16];
    logic [ARQ-1:0] v_rs1, v_rs2, v_rd;

    // Writeback bypass so a value retiring this cycle is visible to decode.
    assign v_rs1 = (f_rs1 == 4'd0) ? '0 : (wb_we && wb_rd == f_rs1) ? wb_data : rf[f_rs1];
    assign v_rs2 = (f_rs2 == 4'd0) ? '0 : (wb_we && wb_rd == f_rs2) ? wb_data : rf[f_rs2];
    assign v_rd  = (f_rd  == 4'd0) ? '0 : (wb_we && wb_rd == f_rd)  ? wb_data : rf[f_rd];

    logic use_rs1, use_rs2, use_rd, load_use, branch_hazard, go;

    always_comb begin
        use_rs1 = (op >= 4'h1 && op <= 4'h8) || op == 4'hA || op == 4'hB;
        use_rs2 = (op >= 4'h1 && op <= 4'h5);
        use_rd  = (op == 4'hB) || (op == 4'hC);
        load_use = id_valid && ex.ex_valid && ex.ex_mem_rd && ex.ex_rd != 4'd0 &&
                   ((use_rs1 && f_rs1 == ex.ex_rd) || (use_rs2 && f_rs2 == ex.ex_rd) ||
                    (use_rd && f_rd == ex.ex_rd));
        // BNZ resolves in decode, so it must wait for any in-flight writer of its source.
        branch_hazard = id_valid && op == 4'hC && f_rd != 4'd0 &&
                        ((ex.ex_valid && ex.ex_we && ex.ex_rd == f_rd) ||
                         (mem_we && mem_rd == f_rd));
    end

    assign stall = load_use | branch_hazard;
    assign go    = id_valid & ~stall;

    always_comb begin
        branch_taken = 1'b0;
        jump_address = '0;
        if (go && op == 4'hD) begin
            branch_taken = 1'b1;
            jump_address = MEM_ADDR'(instr[11:0]);
        end else if (go && op == 4'hC && v_rd != '0) begin
            branch_taken = 1'b1;
            jump_address = pc + MEM_ADDR'($signed(instr[7:0]));
        end
    end

    logic           n_valid, n_we, n_mem_rd, n_mem_wr;
    logic [2:0]     n_alu_op;
    logic [3:0]     n_rd;
    logic [ARQ-1:0] n_a, n_b, n_store;

    always_comb begin
        n_valid  = 1'b0;
        n_we     = 1'b0;
        n_mem_rd = 1'b0;
        n_mem_wr = 1'b0;
        n_alu_op = 3'd0;
        n_rd     = 4'd0;
        n_a      = '0;
        n_b      = '0;
        n_store  = '0;
        if (go && op >= 4'h1 && op <= 4'hA) begin
            n_valid = 1'b1;
            n_rd    = f_rd;
            n_we    = (f_rd != 4'd0);
            n_a     = v_rs1;
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                    n_alu_op = 3'(op - 4'h1);
                    n_b      = v_rs2;
                end
                4'h6: begin n_alu_op = 3'd5; n_b = ARQ'(f_rs2); end
                4'h7: begin n_alu_op = 3'd6; n_b = ARQ'(f_rs2); end
                4'h8: n_b = ARQ'($signed(f_rs2));
                4'h9: begin n_a = '0; n_b = ARQ'(instr[7:0]); end
                default: n_mem_rd = 1'b1;
            endcase
        end else if (go && op == 4'hB) begin
            n_valid  = 1'b1;
            n_mem_wr = 1'b1;
            n_a      = v_rs1;
            n_store  = v_rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex.ex_valid  <= 1'b0;
            ex.ex_we     <= 1'b0;
            ex.ex_mem_rd <= 1'b0;
            ex.ex_mem_wr <= 1'b0;
            ex.ex_alu_op <= 3'd0;
            ex.ex_rd     <= 4'd0;
            ex.ex_a      <= '0;
            ex.ex_b      <= '0;
            ex.ex_store  <= '0;
        end else begin
            ex.ex_valid  <= n_valid;
            ex.ex_we     <= n_we;
            ex.ex_mem_rd <= n_mem_rd;
            ex.ex_mem_wr <= n_mem_wr;
            ex.ex_alu_op <= n_alu_op;
            ex.ex_rd     <= n_rd;
            ex.ex_a      <= n_a;
            ex.ex_b      <= n_b;
            ex.ex_store  <= n_store;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_we && wb_rd != 4'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal_q <= 1'b0;
        else if (go && op >= 4'hE) illegal_q <= 1'b1;
    end
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, mid-stall reset sequence, random run vs reference model.
module tb_id_stage;
    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [15:0] instr;
    logic [12:0] pc;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        mem_we;
    logic [3:0]  mem_rd;
    logic        stall;
    logic        branch_taken;
    logic [12:0] jump_address;
    logic        illegal_op;

    id_stage_if #(.ARQ(16)) ex_bus ();

    id_stage #(.ARQ(16), .MEM_ADDR(13)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .pc(pc),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .mem_we(mem_we), .mem_rd(mem_rd),
        .stall(stall), .branch_taken(branch_taken), .jump_address(jump_address),
        .ex(ex_bus), .illegal_op(illegal_op)
    );

`ifdef ID_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [12:0] ja;
        logic        valid;
        logic        we;
        logic        mrd;
        logic        mwr;
        logic [2:0]  alu;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] st;
        logic        ill;
    } exp_t;

    typedef struct {
        logic        v;
        logic [15:0] ins;
        logic [12:0] pc;
        logic        wwe;
        logic [3:0]  wrd;
        logic [15:0] wd;
        logic        mw;
        logic [3:0]  mr;
        logic        has_exp;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [$bits(exp_t)-1:0] exp_q[$];

    // ---------------- reference model state ----------------
    logic [15:0] m_rf [16];
    exp_t        m_ex;
    logic        m_ill;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        m_ex  = '0;
        m_ill = 1'b0;
    endtask

    function automatic logic [15:0] mreg(input logic [3:0] i, input vec_t t);
        if (i == 4'd0) return 16'h0;
        if (t.wwe && t.wrd == i) return t.wd;
        return m_rf[i];
    endfunction

    // Expected combinational outputs plus the ID/EX contents after the next edge.
    function automatic exp_t model_eval(input vec_t t);
        exp_t e;
        int op, rdf, r1, r2, tgt;
        bit src1, src2, srcd, lu, bh, go;
        logic [15:0] ra, rb, rs;
        e   = '0;
        op  = int'(t.ins[15:12]);
        rdf = int'(t.ins[11:8]);
        r1  = int'(t.ins[7:4]);
        r2  = int'(t.ins[3:0]);
        src1 = (op >= 1 && op <= 8) || op == 10 || op == 11;
        src2 = (op >= 1 && op <= 5);
        srcd = (op == 11 || op == 12);
        lu = t.v && m_ex.valid && m_ex.mrd && m_ex.rd != 0 &&
             ((src1 && r1 == int'(m_ex.rd)) || (src2 && r2 == int'(m_ex.rd)) ||
              (srcd && rdf == int'(m_ex.rd)));
        bh = t.v && op == 12 && rdf != 0 &&
             ((m_ex.valid && m_ex.we && int'(m_ex.rd) == rdf) || (t.mw && int'(t.mr) == rdf));
        e.stall = lu || bh;
        go = t.v && !e.stall;
        ra = mreg(t.ins[7:4], t);
        rb = mreg(t.ins[3:0], t);
        rs = mreg(t.ins[11:8], t);
        if (go && op == 13) begin
            e.taken = 1'b1;
            e.ja    = 13'(int'(t.ins[11:0]));
        end
        if (go && op == 12 && rs != 16'h0) begin
            tgt     = (int'(t.pc) + int'($signed(t.ins[7:0]))) & 8191;
            e.taken = 1'b1;
            e.ja    = 13'(tgt);
        end
        if (go && op >= 1 && op <= 10) begin
            e.valid = 1'b1;
            e.rd    = 4'(rdf);
            e.we    = (rdf != 0);
            e.mrd   = (op == 10);
            e.alu   = (op <= 5) ? 3'(op - 1) : (op == 6) ? 3'd5 : (op == 7) ? 3'd6 : 3'd0;
            e.a     = (op == 9) ? 16'h0 : ra;
            if (op <= 5)                 e.b = rb;
            else if (op == 6 || op == 7) e.b = 16'(r2);
            else if (op == 8)            e.b = 16'(int'($signed(t.ins[3:0])));
            else if (op == 9)            e.b = 16'(int'(t.ins[7:0]));
            else                         e.b = 16'h0;
        end
        if (go && op == 11) begin
            e.valid = 1'b1;
            e.mwr   = 1'b1;
            e.a     = ra;
            e.st    = rs;
        end
        e.ill = m_ill || (TRAP && go && op >= 14);
        return e;
    endfunction

    task automatic commit(input vec_t t, input exp_t e);
        if (t.wwe && t.wrd != 4'd0) m_rf[t.wrd] = t.wd;
        m_ex  = e;
        m_ill = e.ill;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, expv);
        end
    endtask

    task automatic cmp_comb(input string tag, input exp_t e);
        chk({tag, ".stall"}, 32'(stall), 32'(e.stall));
        chk({tag, ".branch_taken"}, 32'(branch_taken), 32'(e.taken));
        chk({tag, ".jump_address"}, 32'(jump_address), 32'(e.ja));
    endtask

    task automatic cmp_regs(input string tag, input exp_t e);
        chk({tag, ".ex_valid"}, 32'(ex_bus.ex_valid), 32'(e.valid));
        chk({tag, ".ex_we"}, 32'(ex_bus.ex_we), 32'(e.we));
        chk({tag, ".ex_mem_rd"}, 32'(ex_bus.ex_mem_rd), 32'(e.mrd));
        chk({tag, ".ex_mem_wr"}, 32'(ex_bus.ex_mem_wr), 32'(e.mwr));
        chk({tag, ".ex_alu_op"}, 32'(ex_bus.ex_alu_op), 32'(e.alu));
        chk({tag, ".ex_rd"}, 32'(ex_bus.ex_rd), 32'(e.rd));
        chk({tag, ".ex_a"}, 32'(ex_bus.ex_a), 32'(e.a));
        chk({tag, ".ex_b"}, 32'(ex_bus.ex_b), 32'(e.b));
        chk({tag, ".ex_store"}, 32'(ex_bus.ex_store), 32'(e.st));
        chk({tag, ".illegal_op"}, 32'(illegal_op), 32'(e.ill));
    endtask

    // ---------------- driver ----------------
    task automatic apply(input vec_t t);
        id_valid = t.v;
        instr    = t.ins;
        pc       = t.pc;
        wb_we    = t.wwe;
        wb_rd    = t.wrd;
        wb_data  = t.wd;
        mem_we   = t.mw;
        mem_rd   = t.mr;
    endtask

    task automatic cycle(input vec_t t, input string tag);
        exp_t m;
        #1;
        m = model_eval(t);
        cmp_comb({tag, " model"}, m);
        if (t.has_exp) cmp_comb({tag, " table"}, t.e);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        m = exp_t'(exp_q.pop_front());
        commit(t, m);
        cmp_regs({tag, " model"}, m);
        if (t.has_exp) cmp_regs({tag, " table"}, t.e);
    endtask

    function automatic vec_t vin(input logic v, input logic [15:0] ins, input logic [12:0] p,
                                 input logic wwe, input logic [3:0] wrd, input logic [15:0] wd,
                                 input logic mw, input logic [3:0] mr);
        vec_t t;
        t.v = v; t.ins = ins; t.pc = p; t.wwe = wwe; t.wrd = wrd; t.wd = wd;
        t.mw = mw; t.mr = mr; t.has_exp = 1'b0; t.e = '0;
        return t;
    endfunction

    // Row whose ID/EX result is a bubble.
    function automatic vec_t vb(input logic v, input logic [15:0] ins, input logic [12:0] p,
                                input logic wwe, input logic [3:0] wrd, input logic [15:0] wd,
                                input logic mw, input logic [3:0] mr,
                                input logic st, input logic tk, input logic [12:0] ja,
                                input logic ill);
        vec_t t;
        t = vin(v, ins, p, wwe, wrd, wd, mw, mr);
        t.has_exp = 1'b1;
        t.e.stall = st; t.e.taken = tk; t.e.ja = ja; t.e.ill = ill;
        return t;
    endfunction

    // Row whose instruction issues into ID/EX.
    function automatic vec_t vi(input logic [15:0] ins, input logic [12:0] p,
                                input logic wwe, input logic [3:0] wrd, input logic [15:0] wd,
                                input logic we, input logic mrd, input logic mwr,
                                input logic [2:0] alu, input logic [3:0] rd,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] st, input logic ill);
        vec_t t;
        t = vin(1'b1, ins, p, wwe, wrd, wd, 1'b0, 4'd0);
        t.has_exp = 1'b1;
        t.e.valid = 1'b1; t.e.we = we; t.e.mrd = mrd; t.e.mwr = mwr; t.e.alu = alu;
        t.e.rd = rd; t.e.a = a; t.e.b = b; t.e.st = st; t.e.ill = ill;
        return t;
    endfunction

    vec_t tab[24];

    initial begin
        vec_t t;
        exp_t zero;
        zero = '0;

        tab[0]  = vi(16'h912A, 13'h0000, 0, 4'd0, 16'h0,    1, 0, 0, 3'd0, 4'd1, 16'h0000, 16'h002A, 16'h0, 0);
        tab[1]  = vb(0, 16'h0000, 13'h0000, 1, 4'd1, 16'h002A, 0, 4'd0, 0, 0, 13'h0, 0);
        tab[2]  = vi(16'h1211, 13'h0002, 0, 4'd0, 16'h0,    1, 0, 0, 3'd0, 4'd2, 16'h002A, 16'h002A, 16'h0, 0);
        tab[3]  = vi(16'h1430, 13'h0003, 1, 4'd3, 16'h1234, 1, 0, 0, 3'd0, 4'd4, 16'h1234, 16'h0000, 16'h0, 0);
        tab[4]  = vi(16'hA510, 13'h0004, 0, 4'd0, 16'h0,    1, 1, 0, 3'd0, 4'd5, 16'h002A, 16'h0000, 16'h0, 0);
        tab[5]  = vb(1, 16'h1652, 13'h0005, 0, 4'd0, 16'h0, 0, 4'd0, 1, 0, 13'h0, 0);
        tab[6]  = vi(16'h1652, 13'h0005, 0, 4'd0, 16'h0,    1, 0, 0, 3'd0, 4'd6, 16'h0000, 16'h0000, 16'h0, 0);
        tab[7]  = vb(0, 16'h0000, 13'h0000, 1, 4'd7, 16'h0001, 0, 4'd0, 0, 0, 13'h0, 0);
        tab[8]  = vb(1, 16'hC7FE, 13'h0010, 0, 4'd0, 16'h0, 0, 4'd0, 0, 1, 13'h000E, 0);
        tab[9]  = vb(0, 16'h0000, 13'h0000, 1, 4'd7, 16'h0000, 0, 4'd0, 0, 0, 13'h0, 0);
        tab[10] = vb(1, 16'hC7FE, 13'h0010, 0, 4'd0, 16'h0, 0, 4'd0, 0, 0, 13'h0, 0);
        tab[11] = vb(0, 16'h0000, 13'h0000, 1, 4'd7, 16'h0005, 0, 4'd0, 0, 0, 13'h0, 0);
        tab[12] = vb(1, 16'hC702, 13'h1FFF, 0, 4'd0, 16'h0, 0, 4'd0, 0, 1, 13'h0001, 0);
        tab[13] = vb(1, 16'hDABC, 13'h0005, 0, 4'd0, 16'h0, 0, 4'd0, 0, 1, 13'h0ABC, 0);
        tab[14] = vi(16'h9803, 13'h0020, 0, 4'd0, 16'h0,    1, 0, 0, 3'd0, 4'd8, 16'h0000, 16'h0003, 16'h0, 0);
        tab[15] = vb(1, 16'hC804, 13'h0020, 0, 4'd0, 16'h0, 0, 4'd0, 1, 0, 13'h0, 0);
        tab[16] = vb(1, 16'hC804, 13'h0020, 0, 4'd0, 16'h0, 1, 4'd8, 1, 0, 13'h0, 0);
        tab[17] = vb(1, 16'hC804, 13'h0020, 1, 4'd8, 16'h0003, 0, 4'd0, 0, 1, 13'h0024, 0);
        tab[18] = vb(1, 16'hE123, 13'h0030, 0, 4'd0, 16'h0, 0, 4'd0, 0, 0, 13'h0, TRAP);
        tab[19] = vi(16'hB710, 13'h0031, 0, 4'd0, 16'h0,    0, 0, 1, 3'd0, 4'd0, 16'h002A, 16'h0000, 16'h0005, TRAP);
        tab[20] = vi(16'h6913, 13'h0032, 0, 4'd0, 16'h0,    1, 0, 0, 3'd5, 4'd9, 16'h002A, 16'h0003, 16'h0, TRAP);
        tab[21] = vi(16'h8A1F, 13'h0033, 0, 4'd0, 16'h0,    1, 0, 0, 3'd0, 4'd10, 16'h002A, 16'hFFFF, 16'h0, TRAP);
        tab[22] = vi(16'h1011, 13'h0034, 0, 4'd0, 16'h0,    0, 0, 0, 3'd0, 4'd0, 16'h002A, 16'h002A, 16'h0, TRAP);
        tab[23] = vi(16'h7B12, 13'h0035, 0, 4'd0, 16'h0,    1, 0, 0, 3'd6, 4'd11, 16'h002A, 16'h0002, 16'h0, TRAP);

        // Reset state
        rst = 1'b0;
        apply(vin(0, 16'h0, 13'h0, 0, 4'd0, 16'h0, 0, 4'd0));
        model_reset();
        #12;
        cmp_comb("reset", zero);
        cmp_regs("reset", zero);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 24; i++) begin
            apply(tab[i]);
            cycle(tab[i], $sformatf("tab%0d", i));
        end

        // Reset asserted in the middle of a load-use stall
        t = vin(1, 16'hA510, 13'h0040, 0, 4'd0, 16'h0, 0, 4'd0);
        apply(t);
        cycle(t, "rs_ld");
        t = vin(1, 16'h1652, 13'h0041, 0, 4'd0, 16'h0, 0, 4'd0);
        apply(t);
        #1;
        chk("rs_stall_before", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rs_async_ex_valid", 32'(ex_bus.ex_valid), 32'd0);
        chk("rs_async_ex_mem_rd", 32'(ex_bus.ex_mem_rd), 32'd0);
        chk("rs_async_ex_a", 32'(ex_bus.ex_a), 32'd0);
        chk("rs_async_ex_rd", 32'(ex_bus.ex_rd), 32'd0);
        chk("rs_async_illegal", 32'(illegal_op), 32'd0);
        chk("rs_async_stall", 32'(stall), 32'd0);
        #1 rst = 1'b1;
        t.has_exp = 1'b1;
        t.e = '0;
        t.e.valid = 1'b1; t.e.we = 1'b1; t.e.rd = 4'd6;
        cycle(t, "rs_release");
        t = vin(1, 16'h1211, 13'h0042, 0, 4'd0, 16'h0, 0, 4'd0);
        t.has_exp = 1'b1;
        t.e = '0;
        t.e.valid = 1'b1; t.e.we = 1'b1; t.e.rd = 4'd2;
        apply(t);
        cycle(t, "rs_rf_cleared");

        // Randomized run against the reference model
        for (int n = 0; n < 600; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            t = vin(($urandom_range(0, 3) != 0), ins, 13'($urandom),
                    ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 4)), 16'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 4)));
            apply(t);
            cycle(t, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
